mipi_csi2_depacketizer: RTL and testbench
=========================================

Name: mipi_csi2_depacketizer

Overview:
Receive-side CSI-2 packet layer. It consumes the byte stream from the PHY deserializer in the clk_hs domain and parses short and long packets. It regenerates the vsync/href/data pixel interface that the serializer consumes, unpacking RAW10 to pixels, and reports frame number, line word count and error pulses. It is used as the loopback checker for the TX chain and as the front end of a CSI-2 receive path.

Parameters:
DATA_WIDTH, 10, output pixel bus width; must be ≥10
CHECK_CRC, 1, 1 = verify payload CRC-16; 0 = ignore checksum bytes

Ports:
clk_hs  in  1  byte clock from the PHY deserializer
resetb  in  1  asynchronous active-low reset
enable  in  1  0 forces IDLE and zeroes all outputs
rx_active  in  1  high from SoT to EoT of one HS burst
rx_valid  in  1  rx_data valid this cycle
rx_data  in  8  received byte
vsync  out  1  high from Frame Start to Frame End
href  out  1  per-pixel valid strobe, asserted only while vsync is high
data  out  DATA_WIDTH  pixel value, zero-extended
pixel_width  out  4  8 or 10; latched from the last long packet's data type
frame_num  out  16  WC of the last Frame Start packet
line_wc  out  16  WC of the last long packet
err_dt  out  1  one-cycle pulse: unknown data type
err_trunc  out  1  one-cycle pulse: rx_active fell mid-packet
err_crc  out  1  one-cycle pulse: checksum mismatch (only when CHECK_CRC=1)

Behaviour:
- Reset (async) or enable=0: state IDLE; every output is 0, except pixel_width, which resets to 8.
- One packet per burst. Bytes are consumed only when rx_valid=1. Header is DI, WC[7:0], WC[15:8], ECC. The ECC byte is skipped and not checked.
- State machine:
  - IDLE: wait for rx_active=1 and rx_valid=1; capture DI and go to HDR.
  - HDR: capture WC low byte, then WC high byte; go to ECC.
  - ECC: on the ECC byte:
    - DT 0x00 or 0x01: act on the short packet, go to WAIT_EOT.
    - DT 0x2A or 0x2B: latch line_wc and pixel_width; go to PAYLOAD, or to CRC if WC=0.
    - Other DT: pulse err_dt, go to WAIT_EOT.
  - PAYLOAD: consume WC bytes, then go to CRC.
  - CRC: consume checksum low then high byte; compare; go to WAIT_EOT.
  - WAIT_EOT: ignore bytes until rx_active=0, then go to IDLE.
- Short packet actions, applied on the cycle after the ECC byte is accepted:
  - DT 0x00 (Frame Start): vsync←1, frame_num←WC. An FS while vsync is already high keeps vsync high and updates frame_num.
  - DT 0x01 (Frame End): vsync←0. An FE while vsync is low is ignored.
  - DT 0x02 and 0x03 are accepted and ignored.
- RAW8: each payload byte appears on data with href=1 exactly one cycle after it is accepted.
- RAW10:
  - Bytes are grouped by a 0..4 position counter. Bytes 0–3 are held as pixel[9:2]. Byte 4 supplies the LSBs: pixel k gets bits [2k+1:2k].
  - After byte 4 is accepted, the four pixels are emitted on the next 4 cycles, one per cycle, with href=1. The next group's LSB byte cannot arrive sooner, so no overlap occurs.
  - If WC is not a multiple of 5, the trailing partial group is discarded and err_dt is pulsed at CRC entry.
- href is asserted only while vsync=1. Payload received while vsync=0 is parsed but not output.
- CRC: CSI-2 CRC-16, polynomial 0x1021 processed LSB-first, seed 0xFFFF, computed over payload bytes only. The received value is little-endian. On mismatch, err_crc pulses one cycle after the high checksum byte is accepted.
- rx_active falling in any state other than IDLE or WAIT_EOT: pulse err_trunc, drop href immediately, discard RAW10 pixels not yet emitted, go to IDLE. vsync is unchanged.
- Simultaneous final RAW10 drain and a new packet's DI: the drain completes and DI is captured normally (pipelines are independent).

Decomposition:
- Package mipi_csi2_pkg holds:
  - DT constants: DT_FS=0x00, DT_FE=0x01, DT_LS=0x02, DT_LE=0x03, DT_RAW8=0x2A, DT_RAW10=0x2B.
  - State encoding.
  - CRC polynomial and seed.
- Sub-module mipi_csi2_crc16: byte-wide combinational next-CRC function plus register, with clear and enable inputs. It is shared with a future transmit-side CRC fix.

Test Plan:
1. FS (DI 0x00, WC 0x0007) → vsync=1 one cycle after the ECC byte; frame_num=7. Then FE → vsync=0.
2. FS; RAW8 long packet, WC=4, bytes 11 22 33 44, valid CRC → four href pulses with data 0x11,0x22,0x33,0x44; line_wc=4; no err_crc.
3. RAW10 packet, WC=5, bytes AA BB CC DD 1B → pixels 0x2AB, 0x2EE, 0x331, 0x374 on four consecutive cycles; pixel_width=10.
4. Same as scenario 2 but with the CRC low byte corrupted and CHECK_CRC=1 → err_crc pulse; pixels still output. With CHECK_CRC=0 → no pulse.
5. rx_active dropped after 2 RAW10 payload bytes → err_trunc pulse; no href; the next FS packet parses correctly.
6. DI 0x12 → err_dt pulse; outputs unchanged. resetb asserted mid-payload → all outputs 0 immediately; the next burst parses correctly.

Source files
------------

// File: rtl/mipi_csi2_pkg.sv
// Shared constants for the CSI-2 receive packet layer: data types, FSM encoding and CRC setup.
package mipi_csi2_pkg;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_LS    = 6'h02;
    localparam logic [5:0] DT_LE    = 6'h03;
    localparam logic [5:0] DT_RAW8  = 6'h2A;
    localparam logic [5:0] DT_RAW10 = 6'h2B;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_HDR      = 3'd1;
    localparam logic [2:0] ST_ECC      = 3'd2;
    localparam logic [2:0] ST_PAYLOAD  = 3'd3;
    localparam logic [2:0] ST_CRC      = 3'd4;
    localparam logic [2:0] ST_WAIT_EOT = 3'd5;

    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

    localparam logic [15:0] CRC_POLY      = 16'h1021;
    // The LSB-first shift register uses the bit-reversed polynomial.
    localparam logic [15:0] CRC_POLY_REFL = reflect16(CRC_POLY);
    localparam logic [15:0] CRC_SEED      = 16'hFFFF;

endpackage

// File: rtl/mipi_csi2_crc16.sv
// Byte-wide CSI-2 CRC-16 accumulator with synchronous clear and per-byte enable.
module mipi_csi2_crc16
    import mipi_csi2_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q, crc_d;

    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ b[i]) ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = CRC_SEED;
        end else if (enable_i) begin
            crc_d = crc16_next(crc_q, data_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= CRC_SEED;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/mipi_csi2_depacketizer.sv
// CSI-2 receive packet layer: parses one packet per HS burst and rebuilds a vsync/href pixel bus.
module mipi_csi2_depacketizer
    import mipi_csi2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 10,
    parameter bit          CHECK_CRC  = 1'b1
) (
    input  logic                  clk_hs_i,
    input  logic                  resetb_i,
    input  logic                  enable_i,
    input  logic                  rx_active_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  vsync_o,
    output logic                  href_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [3:0]            pixel_width_o,
    output logic [15:0]           frame_num_o,
    output logic [15:0]           line_wc_o,
    output logic                  err_dt_o,
    output logic                  err_trunc_o,
    output logic                  err_crc_o
);

    logic [2:0]            state_q, state_d;
    logic                  hdr_cnt_q, hdr_cnt_d;
    logic [5:0]            dt_q, dt_d;
    logic [15:0]           wc_q, wc_d, cnt_q, cnt_d;
    logic [2:0]            pos_q, pos_d;
    logic [3:0][7:0]       msb_q, msb_d;
    logic [2:0][9:0]       pend_q, pend_d;
    logic [1:0]            drain_q, drain_d;
    logic                  crc_phase_q, crc_phase_d;
    logic [7:0]            crc_lo_q, crc_lo_d;
    logic                  vsync_q, vsync_d, href_q, href_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [3:0]            pw_q, pw_d;
    logic [15:0]           frame_q, frame_d, line_wc_q, line_wc_d;
    logic                  err_dt_q, err_dt_d, err_trunc_q, err_trunc_d, err_crc_q, err_crc_d;
    logic                  trunc, crc_clr, crc_en;
    logic [15:0]           crc_val;

    mipi_csi2_crc16 u_crc (
        .clk_i   (clk_hs_i),
        .rst_ni  (resetb_i),
        .clear_i (crc_clr),
        .enable_i(crc_en),
        .data_i  (rx_data_i),
        .crc_o   (crc_val)
    );

    assign trunc = (state_q != ST_IDLE) && (state_q != ST_WAIT_EOT) && !rx_active_i;

    always_comb begin
        state_d = state_q;  hdr_cnt_d = hdr_cnt_q;  dt_d = dt_q;  wc_d = wc_q;  cnt_d = cnt_q;
        pos_d = pos_q;  msb_d = msb_q;  pend_d = pend_q;  drain_d = drain_q;
        crc_phase_d = crc_phase_q;  crc_lo_d = crc_lo_q;  vsync_d = vsync_q;  href_d = 1'b0;
        data_d = data_q;  pw_d = pw_q;  frame_d = frame_q;  line_wc_d = line_wc_q;
        err_dt_d = 1'b0;  err_trunc_d = 1'b0;  err_crc_d = 1'b0;  crc_clr = 1'b0;  crc_en = 1'b0;

        // RAW10 pixels buffered behind the LSB byte drain one per cycle.
        if (drain_q != 2'd0) begin
            href_d  = vsync_q;
            data_d  = DATA_WIDTH'(pend_q[0]);
            pend_d  = {10'd0, pend_q[2], pend_q[1]};
            drain_d = drain_q - 2'd1;
        end

        if (trunc) begin
            state_d     = ST_IDLE;
            href_d      = 1'b0;
            drain_d     = 2'd0;
            err_trunc_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_active_i && rx_valid_i) begin
                        dt_d      = rx_data_i[5:0];
                        hdr_cnt_d = 1'b0;
                        crc_clr   = 1'b1;
                        state_d   = ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (rx_valid_i) begin
                        if (!hdr_cnt_q) begin
                            wc_d[7:0] = rx_data_i;
                            hdr_cnt_d = 1'b1;
                        end else begin
                            wc_d[15:8] = rx_data_i;
                            state_d    = ST_ECC;
                        end
                    end
                end
                ST_ECC: begin
                    if (rx_valid_i) begin
                        state_d = ST_WAIT_EOT;
                        case (dt_q)
                            DT_FS: begin
                                vsync_d = 1'b1;
                                frame_d = wc_q;
                            end
                            DT_FE:        vsync_d = 1'b0;
                            DT_LS, DT_LE: ;
                            DT_RAW8, DT_RAW10: begin
                                line_wc_d   = wc_q;
                                pw_d        = (dt_q == DT_RAW10) ? 4'd10 : 4'd8;
                                cnt_d       = wc_q;
                                pos_d       = 3'd0;
                                crc_phase_d = 1'b0;
                                state_d     = (wc_q == 16'd0) ? ST_CRC : ST_PAYLOAD;
                            end
                            default:      err_dt_d = 1'b1;
                        endcase
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_valid_i) begin
                        crc_en = 1'b1;
                        cnt_d  = cnt_q - 16'd1;
                        if (dt_q == DT_RAW10) begin
                            if (pos_q == 3'd4) begin
                                href_d    = vsync_q;
                                data_d    = DATA_WIDTH'({msb_q[0], rx_data_i[1:0]});
                                pend_d[0] = {msb_q[1], rx_data_i[3:2]};
                                pend_d[1] = {msb_q[2], rx_data_i[5:4]};
                                pend_d[2] = {msb_q[3], rx_data_i[7:6]};
                                drain_d   = 2'd3;
                                pos_d     = 3'd0;
                            end else begin
                                msb_d[pos_q[1:0]] = rx_data_i;
                                pos_d             = pos_q + 3'd1;
                            end
                        end else begin
                            href_d = vsync_q;
                            data_d = DATA_WIDTH'(rx_data_i);
                        end
                        if (cnt_q == 16'd1) begin
                            state_d  = ST_CRC;
                            err_dt_d = (dt_q == DT_RAW10) && (pos_d != 3'd0);
                        end
                    end
                end
                ST_CRC: begin
                    if (rx_valid_i) begin
                        if (!crc_phase_q) begin
                            crc_lo_d    = rx_data_i;
                            crc_phase_d = 1'b1;
                        end else begin
                            err_crc_d = CHECK_CRC && ({rx_data_i, crc_lo_q} != crc_val);
                            state_d   = ST_WAIT_EOT;
                        end
                    end
                end
                ST_WAIT_EOT: begin
                    if (!rx_active_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (!enable_i) begin
            state_d = ST_IDLE;  vsync_d = 1'b0;  href_d = 1'b0;  data_d = '0;  drain_d = 2'd0;
            pw_d = 4'd8;  frame_d = 16'd0;  line_wc_d = 16'd0;
            err_dt_d = 1'b0;  err_trunc_d = 1'b0;  err_crc_d = 1'b0;
        end
    end

    always_ff @(posedge clk_hs_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= ST_IDLE;  hdr_cnt_q <= 1'b0;  dt_q <= 6'd0;  wc_q <= 16'd0;
            cnt_q <= 16'd0;  pos_q <= 3'd0;  msb_q <= '0;  pend_q <= '0;  drain_q <= 2'd0;
            crc_phase_q <= 1'b0;  crc_lo_q <= 8'd0;  vsync_q <= 1'b0;  href_q <= 1'b0;
            data_q <= '0;  pw_q <= 4'd8;  frame_q <= 16'd0;  line_wc_q <= 16'd0;
            err_dt_q <= 1'b0;  err_trunc_q <= 1'b0;  err_crc_q <= 1'b0;
        end else begin
            state_q <= state_d;  hdr_cnt_q <= hdr_cnt_d;  dt_q <= dt_d;  wc_q <= wc_d;
            cnt_q <= cnt_d;  pos_q <= pos_d;  msb_q <= msb_d;  pend_q <= pend_d;  drain_q <= drain_d;
            crc_phase_q <= crc_phase_d;  crc_lo_q <= crc_lo_d;  vsync_q <= vsync_d;  href_q <= href_d;
            data_q <= data_d;  pw_q <= pw_d;  frame_q <= frame_d;  line_wc_q <= line_wc_d;
            err_dt_q <= err_dt_d;  err_trunc_q <= err_trunc_d;  err_crc_q <= err_crc_d;
        end
    end

    // href drops in the same cycle a truncation is seen, not one cycle later.
    assign vsync_o       = enable_i & vsync_q;
    assign href_o        = enable_i & href_q & ~trunc;
    assign data_o        = enable_i ? data_q : '0;
    assign pixel_width_o = enable_i ? pw_q : 4'd8;
    assign frame_num_o   = enable_i ? frame_q : 16'd0;
    assign line_wc_o     = enable_i ? line_wc_q : 16'd0;
    assign err_dt_o      = enable_i & err_dt_q;
    assign err_trunc_o   = enable_i & err_trunc_q;
    assign err_crc_o     = enable_i & err_crc_q;

endmodule

// File: tb/tb_mipi_csi2_depacketizer.sv
// Scoreboard bench for the CSI-2 depacketizer; a CHECK_CRC=0 twin shares the same stimulus.
module tb_mipi_csi2_depacketizer;

    localparam int DW = 12;

    logic          clk_hs = 1'b0;
    logic          resetb, enable, rx_active, rx_valid;
    logic [7:0]    rx_data;
    logic          vsync, href, err_dt, err_trunc, err_crc;
    logic [DW-1:0] data;
    logic [3:0]    pixel_width;
    logic [15:0]   frame_num, line_wc;
    logic          nc_vsync, nc_href, nc_err_dt, nc_err_trunc, nc_err_crc;
    logic [DW-1:0] nc_data;
    logic [3:0]    nc_pixel_width;
    logic [15:0]   nc_frame_num, nc_line_wc;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q[$];
    logic [7:0]    pl_q[$];
    bit            exp_vsync;
    logic [15:0]   exp_frame, exp_line_wc;
    int            dt_cnt, trunc_cnt, crc_cnt, crc_nc_cnt, href_cnt, run_len, max_run;

    always #5 clk_hs = ~clk_hs;

    mipi_csi2_depacketizer #(.DATA_WIDTH(DW), .CHECK_CRC(1'b1)) dut (
        .clk_hs_i(clk_hs), .resetb_i(resetb), .enable_i(enable), .rx_active_i(rx_active),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data), .vsync_o(vsync), .href_o(href),
        .data_o(data), .pixel_width_o(pixel_width), .frame_num_o(frame_num),
        .line_wc_o(line_wc), .err_dt_o(err_dt), .err_trunc_o(err_trunc), .err_crc_o(err_crc)
    );

    mipi_csi2_depacketizer #(.DATA_WIDTH(DW), .CHECK_CRC(1'b0)) dut_nc (
        .clk_hs_i(clk_hs), .resetb_i(resetb), .enable_i(enable), .rx_active_i(rx_active),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data), .vsync_o(nc_vsync), .href_o(nc_href),
        .data_o(nc_data), .pixel_width_o(nc_pixel_width), .frame_num_o(nc_frame_num),
        .line_wc_o(nc_line_wc), .err_dt_o(nc_err_dt), .err_trunc_o(nc_err_trunc),
        .err_crc_o(nc_err_crc)
    );

    // Output monitor: pops the scoreboard on every href and counts error pulse cycles.
    always @(negedge clk_hs) begin : monitor
        logic [DW-1:0] e;
        if (href === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_href: got data=%h, required no pixel", data);
            end else begin
                e = exp_q.pop_front();
                if (data !== e) begin
                    n_fail++;
                    $display("FAIL pixel: got %h, required %h", data, e);
                end
            end
            href_cnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (err_dt === 1'b1) dt_cnt++;
        if (err_trunc === 1'b1) trunc_cnt++;
        if (err_crc === 1'b1) crc_cnt++;
        if (nc_err_crc === 1'b1) crc_nc_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Non-reflected CRC over bit-reversed bytes, result reversed: equals the LSB-first CRC.
    function automatic logic [15:0] model_crc();
        logic [15:0] c, o;
        logic [7:0]  r;
        c = 16'hFFFF;
        foreach (pl_q[i]) begin
            for (int j = 0; j < 8; j++) r[j] = pl_q[i][7-j];
            c = c ^ {r, 8'h00};
            for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        for (int j = 0; j < 16; j++) o[j] = c[15-j];
        return o;
    endfunction

    task automatic clear_counts();
        dt_cnt = 0; trunc_cnt = 0; crc_cnt = 0; crc_nc_cnt = 0; href_cnt = 0; max_run = 0;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        @(posedge clk_hs); #1;
        rx_active = 1'b1;
        rx_valid  = 1'b1;
        rx_data   = b;
    endtask

    task automatic end_burst();
        @(posedge clk_hs); #1;
        rx_valid  = 1'b0;
        rx_active = 1'b0;
        repeat (5) @(posedge clk_hs);
        #1;
    endtask

    task automatic send_header(input logic [7:0] di, input logic [15:0] wc);
        drive_byte(di);
        drive_byte(wc[7:0]);
        drive_byte(wc[15:8]);
        drive_byte(8'h00);
    endtask

    task automatic send_short(input logic [7:0] di, input logic [15:0] wc);
        send_header(di, wc);
        end_burst();
        if (di[5:0] == 6'h00) begin
            exp_vsync = 1'b1;
            exp_frame = wc;
        end else if (di[5:0] == 6'h01) begin
            exp_vsync = 1'b0;
        end
    endtask

    task automatic send_long(input logic [7:0] di, input bit corrupt, input bit auto_exp);
        logic [15:0] crc;
        logic [7:0]  lsb;
        if (auto_exp && exp_vsync) begin
            if (di == 8'h2A) begin
                foreach (pl_q[i]) exp_q.push_back(DW'(pl_q[i]));
            end else begin
                for (int g = 0; g + 4 < pl_q.size(); g += 5) begin
                    lsb = pl_q[g+4];
                    for (int k = 0; k < 4; k++) exp_q.push_back(DW'({pl_q[g+k], lsb[2*k +: 2]}));
                end
            end
        end
        exp_line_wc = 16'(pl_q.size());
        crc = model_crc();
        send_header(di, 16'(pl_q.size()));
        foreach (pl_q[i]) drive_byte(pl_q[i]);
        drive_byte(crc[7:0] ^ (corrupt ? 8'h5A : 8'h00));
        drive_byte(crc[15:8]);
        end_burst();
    endtask

    task automatic test_reset();
        n_checks++; if (vsync !== 1'b0) begin n_fail++; $display("FAIL reset_vsync: got %b, required 0", vsync); end
        n_checks++; if (href !== 1'b0) begin n_fail++; $display("FAIL reset_href: got %b, required 0", href); end
        n_checks++; if (data !== '0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", data); end
        n_checks++; if (pixel_width !== 4'd8) begin n_fail++; $display("FAIL reset_pw: got %0d, required 8", pixel_width); end
        n_checks++; if (frame_num !== 16'd0) begin n_fail++; $display("FAIL reset_frame: got %h, required 0", frame_num); end
        n_checks++; if (line_wc !== 16'd0) begin n_fail++; $display("FAIL reset_line_wc: got %h, required 0", line_wc); end
        n_checks++; if ({err_dt, err_trunc, err_crc} !== 3'b000) begin
            n_fail++; $display("FAIL reset_errs: got %b, required 000", {err_dt, err_trunc, err_crc});
        end
    endtask

    task automatic test_frame_start();
        send_header(8'h00, 16'h0007);
        @(negedge clk_hs);
        n_checks++; if (vsync !== 1'b0) begin n_fail++; $display("FAIL fs_early: vsync got %b, required 0", vsync); end
        @(posedge clk_hs); #1;
        rx_valid = 1'b0; rx_active = 1'b0;
        @(negedge clk_hs);
        n_checks++; if (vsync !== 1'b1) begin n_fail++; $display("FAIL fs_vsync: got %b, required 1", vsync); end
        n_checks++; if (frame_num !== 16'h0007) begin n_fail++; $display("FAIL fs_frame: got %h, required 0007", frame_num); end
        repeat (4) @(posedge clk_hs);
        #1;
        exp_vsync = 1'b1; exp_frame = 16'h0007;
        send_short(8'h01, 16'h0000);
        n_checks++; if (vsync !== 1'b0) begin n_fail++; $display("FAIL fe_vsync: got %b, required 0", vsync); end
        send_short(8'h01, 16'h0000);
        n_checks++; if (vsync !== 1'b0 || frame_num !== exp_frame) begin
            n_fail++; $display("FAIL fe_idle: got vsync=%b frame=%h, required 0/%h", vsync, frame_num, exp_frame);
        end
        send_short(8'h00, 16'h0008);
        send_short(8'h00, 16'h0009);
        n_checks++; if (vsync !== 1'b1 || frame_num !== 16'h0009) begin
            n_fail++; $display("FAIL fs_repeat: got vsync=%b frame=%h, required 1/0009", vsync, frame_num);
        end
    endtask

    task automatic test_raw8();
        clear_counts();
        send_short(8'h00, 16'h0001);
        pl_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q.push_back(12'h011); exp_q.push_back(12'h022);
        exp_q.push_back(12'h033); exp_q.push_back(12'h044);
        send_long(8'h2A, 1'b0, 1'b0);
        n_checks++; if (href_cnt != 4 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL raw8_count: got %0d href, %0d left, required 4/0", href_cnt, exp_q.size());
        end
        n_checks++; if (line_wc !== 16'd4) begin n_fail++; $display("FAIL raw8_line_wc: got %0d, required 4", line_wc); end
        n_checks++; if (pixel_width !== 4'd8) begin n_fail++; $display("FAIL raw8_pw: got %0d, required 8", pixel_width); end
        n_checks++; if (crc_cnt != 0) begin n_fail++; $display("FAIL raw8_crc: got %0d pulses, required 0", crc_cnt); end
    endtask

    task automatic test_raw10();
        clear_counts();
        pl_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h1B};
        exp_q.push_back(12'h2AB); exp_q.push_back(12'h2EE);
        exp_q.push_back(12'h331); exp_q.push_back(12'h374);
        send_long(8'h2B, 1'b0, 1'b0);
        n_checks++; if (max_run != 4 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL raw10_run: got run %0d, %0d left, required 4/0", max_run, exp_q.size());
        end
        n_checks++; if (pixel_width !== 4'd10) begin n_fail++; $display("FAIL raw10_pw: got %0d, required 10", pixel_width); end
        n_checks++; if (dt_cnt != 0 || crc_cnt != 0) begin
            n_fail++; $display("FAIL raw10_errs: got dt=%0d crc=%0d, required 0/0", dt_cnt, crc_cnt);
        end
        clear_counts();
        pl_q.delete();
        for (int i = 0; i < 10; i++) pl_q.push_back(8'($urandom_range(0, 255)));
        send_long(8'h2B, 1'b0, 1'b1);
        n_checks++; if (href_cnt != 8 || exp_q.size() != 0 || crc_cnt != 0) begin
            n_fail++; $display("FAIL raw10_two: got %0d href crc=%0d, required 8/0", href_cnt, crc_cnt);
        end
        clear_counts();
        pl_q.delete();
        for (int i = 0; i < 7; i++) pl_q.push_back(8'($urandom_range(0, 255)));
        send_long(8'h2B, 1'b0, 1'b1);
        n_checks++; if (dt_cnt != 1 || href_cnt != 4 || line_wc !== 16'd7) begin
            n_fail++; $display("FAIL raw10_partial: got dt=%0d href=%0d wc=%0d, required 1/4/7", dt_cnt, href_cnt, line_wc);
        end
    endtask

    task automatic test_crc_error();
        clear_counts();
        pl_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_long(8'h2A, 1'b1, 1'b1);
        n_checks++; if (crc_cnt != 1) begin n_fail++; $display("FAIL crc_err: got %0d pulse cycles, required 1", crc_cnt); end
        n_checks++; if (crc_nc_cnt != 0) begin n_fail++; $display("FAIL crc_nocheck: got %0d pulses, required 0", crc_nc_cnt); end
        n_checks++; if (href_cnt != 4 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL crc_pixels: got %0d href, required 4", href_cnt);
        end
    endtask

    task automatic test_trunc();
        clear_counts();
        send_header(8'h2B, 16'd5);
        exp_line_wc = 16'd5;
        drive_byte(8'hAA);
        drive_byte(8'hBB);
        @(posedge clk_hs); #1;
        rx_valid = 1'b0; rx_active = 1'b0;
        repeat (6) @(posedge clk_hs);
        #1;
        n_checks++; if (trunc_cnt != 1 || href_cnt != 0) begin
            n_fail++; $display("FAIL trunc: got %0d pulses %0d href, required 1/0", trunc_cnt, href_cnt);
        end
        n_checks++; if (vsync !== exp_vsync) begin n_fail++; $display("FAIL trunc_vsync: got %b, required %b", vsync, exp_vsync); end
        send_short(8'h00, 16'h0021);
        n_checks++; if (frame_num !== 16'h0021 || vsync !== 1'b1) begin
            n_fail++; $display("FAIL trunc_next: got frame=%h vsync=%b, required 0021/1", frame_num, vsync);
        end
    endtask

    task automatic test_bad_dt();
        clear_counts();
        send_short(8'h12, 16'h0033);
        n_checks++; if (dt_cnt != 1) begin n_fail++; $display("FAIL bad_dt: got %0d pulse cycles, required 1", dt_cnt); end
        n_checks++; if (vsync !== exp_vsync || frame_num !== exp_frame || line_wc !== exp_line_wc) begin
            n_fail++; $display("FAIL bad_dt_outputs: got %b/%h/%h, required %b/%h/%h",
                vsync, frame_num, line_wc, exp_vsync, exp_frame, exp_line_wc);
        end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        send_header(8'h2B, 16'd10);
        drive_byte(8'h01); drive_byte(8'h02); drive_byte(8'h03);
        #2;
        resetb = 1'b0; rx_valid = 1'b0; rx_active = 1'b0;
        #1;
        n_checks++; if (vsync !== 1'b0 || pixel_width !== 4'd8 || frame_num !== 16'd0 || line_wc !== 16'd0) begin
            n_fail++; $display("FAIL reset_mid: got %b/%0d/%h/%h, required 0/8/0000/0000",
                vsync, pixel_width, frame_num, line_wc);
        end
        exp_vsync = 1'b0; exp_frame = 16'd0; exp_line_wc = 16'd0;
        @(posedge clk_hs); #1;
        resetb = 1'b1;
        send_short(8'h00, 16'h0055);
        pl_q = '{8'h01, 8'h02, 8'h03};
        send_long(8'h2A, 1'b0, 1'b1);
        n_checks++; if (frame_num !== 16'h0055 || line_wc !== 16'd3 || href_cnt != 3 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL reset_recover: got frame=%h wc=%0d href=%0d, required 0055/3/3",
                frame_num, line_wc, href_cnt);
        end
    endtask

    task automatic test_enable();
        @(posedge clk_hs); #1;
        enable = 1'b0;
        #1;
        n_checks++; if (vsync !== 1'b0 || frame_num !== 16'd0 || pixel_width !== 4'd8) begin
            n_fail++; $display("FAIL enable_off: got %b/%h/%0d, required 0/0000/8", vsync, frame_num, pixel_width);
        end
        repeat (2) @(posedge clk_hs);
        #1;
        enable = 1'b1;
        #1;
        n_checks++; if (vsync !== 1'b0 || frame_num !== 16'd0) begin
            n_fail++; $display("FAIL enable_cleared: got %b/%h, required 0/0000", vsync, frame_num);
        end
        exp_vsync = 1'b0; exp_frame = 16'd0;
        send_short(8'h00, 16'h0003);
        n_checks++; if (vsync !== 1'b1 || frame_num !== 16'h0003) begin
            n_fail++; $display("FAIL enable_resume: got %b/%h, required 1/0003", vsync, frame_num);
        end
    endtask

    initial begin
        resetb = 1'b0; enable = 1'b1; rx_active = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        exp_vsync = 1'b0; exp_frame = 16'd0; exp_line_wc = 16'd0;
        clear_counts();
        #23;
        test_reset();
        @(posedge clk_hs); #1;
        resetb = 1'b1;
        test_frame_start();
        test_raw8();
        test_raw10();
        test_crc_error();
        test_trunc();
        test_bad_dt();
        test_reset_mid();
        test_enable();
        repeat (3) @(posedge clk_hs);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
